// File: rtl/cpu_ctrl_nest.sv
// cpu_ctrl_nest: pipeline stall/flush control, control-register file, prioritised IRQ
// channels and a hardware exception stack for nested exceptions / EXRT returns.
// Optional feature macro: CPU_CTRL_IRQ_EDGE_EN (edge-latched, write-1-to-clear pending bits).
module cpu_ctrl_nest #(
    parameter int unsigned IRQ_CH      = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned ROM_SIZE    = 8192,
    parameter int unsigned SPM_SIZE    = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        creg_rd_addr,
    output logic [31:0]       creg_rd_data,
    output logic              exe_mode,
    input  logic [IRQ_CH-1:0] irq,
    output logic              int_detect,
    output logic [3:0]        int_id,
    input  logic [29:0]       id_pc,
    input  logic [29:0]       mem_pc,
    input  logic              mem_en,
    input  logic              mem_br_flag,
    input  logic [1:0]        mem_ctrl_op,
    input  logic [4:0]        mem_dst_addr,
    input  logic [2:0]        mem_exp_code,
    input  logic [31:0]       mem_out,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ld_hazard,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic [29:0]       new_pc,
    output logic              stack_ovf
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam logic [31:0] CPU_INFO = 32'h4E45_5354;

    typedef struct packed {
        logic        pre_exe_mode;
        logic        pre_int_en;
        logic [29:0] epc;
        logic        dly_flag;
    } stk_entry_t;

    stk_entry_t        stack_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic              stack_ovf_q;
    logic              exe_mode_q;
    logic              int_en_q;
    logic [IRQ_CH-1:0] mask_q;
    logic [29:0]       exp_vector_q;
    logic [2:0]        exp_code_q;
    logic [3:0]        irq_id_q;
    logic [29:0]       pre_pc_q;
    logic              br_flag_q;

    logic              stall;
    logic              flush;
    logic              exp_req;
    logic              exrt_req;
    logic              wrcr_req;
    logic              accept;
    logic              do_exp;
    logic              do_exrt;
    logic              do_wrcr;
    logic              stack_full;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    stk_entry_t        top;
    logic [IRQ_CH-1:0] pending;
    logic [IRQ_CH-1:0] active;

    assign exp_req  = (mem_exp_code != 3'd0);
    assign exrt_req = (mem_ctrl_op == 2'd2);
    assign wrcr_req = (mem_ctrl_op == 2'd1);

    assign stall    = if_busy | mem_busy;
    assign accept   = mem_en & ~stall;
    assign do_exp   = accept & exp_req;
    assign do_exrt  = accept & ~exp_req & exrt_req;
    assign do_wrcr  = accept & ~exp_req & ~exrt_req & wrcr_req;

    assign flush     = mem_en & (exp_req | exrt_req | wrcr_req);
    assign if_stall  = stall | ld_hazard;
    assign id_stall  = stall;
    assign ex_stall  = stall;
    assign mem_stall = stall;
    assign if_flush  = flush;
    assign id_flush  = flush | ld_hazard;
    assign ex_flush  = flush;
    assign mem_flush = flush;

    assign exe_mode  = exe_mode_q;
    assign stack_ovf = stack_ovf_q;

    assign stack_full = (sp_q == SP_W'(STACK_DEPTH));

    // Top-of-stack and push slot; an empty stack aliases slot 0, a full one overwrites the top.
    always_comb begin
        top_idx  = (sp_q == '0) ? '0 : IDX_W'(sp_q - 1'b1);
        push_idx = stack_full ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(sp_q);
    end

    assign top = stack_q[top_idx];

`ifdef CPU_CTRL_IRQ_EDGE_EN
    logic [IRQ_CH-1:0] irq_q;
    logic [IRQ_CH-1:0] pending_q;
    logic [IRQ_CH-1:0] pend_clr;

    assign pend_clr = (do_wrcr && mem_dst_addr == 5'd7) ? mem_out[IRQ_CH-1:0] : '0;
    assign pending  = pending_q;

    // Edge capture runs every cycle, even while stalled; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= '0;
            pending_q <= '0;
        end else begin
            irq_q     <= irq;
            pending_q <= (pending_q & ~pend_clr) | (irq & ~irq_q);
        end
    end
`else
    assign pending = irq;
`endif

    assign active     = ~mask_q & pending;
    assign int_detect = int_en_q & (|active);

    // Priority encoder: scanning downward leaves the lowest active channel.
    always_comb begin
        int_id = 4'd0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (active[i]) int_id = 4'(i);
        end
    end

    // Redirect target follows the MEM inputs regardless of stall.
    always_comb begin
        new_pc = 30'd0;
        if (mem_en && exp_req)       new_pc = exp_vector_q;
        else if (mem_en && exrt_req) new_pc = top.epc;
        else if (mem_en && wrcr_req) new_pc = mem_pc + 30'd1;
    end

    // CREG read mux.
    always_comb begin
        creg_rd_data = 32'd0;
        case (creg_rd_addr)
            5'd0:    creg_rd_data = {30'd0, int_en_q, exe_mode_q};
            5'd1:    creg_rd_data = {30'd0, top.pre_int_en, top.pre_exe_mode};
            5'd2:    creg_rd_data = {id_pc, 2'b00};
            5'd3:    creg_rd_data = {top.epc, 2'b00};
            5'd4:    creg_rd_data = {exp_vector_q, 2'b00};
            5'd5:    creg_rd_data = {20'd0, irq_id_q, 4'd0, top.dly_flag, exp_code_q};
            5'd6:    creg_rd_data = 32'(mask_q);
            5'd7:    creg_rd_data = 32'(pending);
            5'd8:    creg_rd_data = {23'd0, stack_ovf_q, 8'(sp_q)};
            5'd29:   creg_rd_data = 32'(ROM_SIZE);
            5'd30:   creg_rd_data = 32'(SPM_SIZE);
            5'd31:   creg_rd_data = CPU_INFO;
            default: creg_rd_data = 32'd0;
        endcase
    end

    // Architectural state: exception push, EXRT pop, CREG writes, all gated by accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_mode_q   <= 1'b0;
            int_en_q     <= 1'b0;
            mask_q       <= '1;
            exp_vector_q <= 30'd0;
            exp_code_q   <= 3'd0;
            irq_id_q     <= 4'd0;
            pre_pc_q     <= 30'd0;
            br_flag_q    <= 1'b0;
            sp_q         <= '0;
            stack_ovf_q  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else if (accept) begin
            pre_pc_q  <= mem_pc;
            br_flag_q <= mem_br_flag;
            if (do_exp) begin
                // In a delay slot the return point is the preceding branch.
                stack_q[push_idx] <= {exe_mode_q, int_en_q,
                                      (br_flag_q ? pre_pc_q : mem_pc), br_flag_q};
                exe_mode_q <= 1'b0;
                int_en_q   <= 1'b0;
                exp_code_q <= mem_exp_code;
                if (mem_exp_code == 3'd1) irq_id_q <= int_id;
                if (stack_full) stack_ovf_q <= 1'b1;
                else            sp_q        <= sp_q + 1'b1;
            end else if (do_exrt) begin
                exe_mode_q <= top.pre_exe_mode;
                int_en_q   <= top.pre_int_en;
                if (sp_q != '0) sp_q <= sp_q - 1'b1;
            end else if (do_wrcr) begin
                case (mem_dst_addr)
                    5'd0: begin
                        int_en_q   <= mem_out[1];
                        exe_mode_q <= mem_out[0];
                    end
                    5'd1: begin
                        stack_q[top_idx].pre_int_en   <= mem_out[1];
                        stack_q[top_idx].pre_exe_mode <= mem_out[0];
                    end
                    5'd3: stack_q[top_idx].epc <= mem_out[31:2];
                    5'd4: exp_vector_q <= mem_out[31:2];
                    5'd5: begin
                        stack_q[top_idx].dly_flag <= mem_out[3];
                        exp_code_q                <= mem_out[2:0];
                    end
                    5'd6: mask_q <= mem_out[IRQ_CH-1:0];
                    5'd8: if (mem_out[8]) stack_ovf_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_nest.sv
// Self-checking bench for cpu_ctrl_nest: behavioural model compared every cycle on the
// falling edge, directed scenarios with literal expectations, then randomized traffic.
// Honours CPU_CTRL_IRQ_EDGE_EN the same way as the design.
module tb_cpu_ctrl_nest;

    localparam int DEPTH = 4;
    localparam logic [31:0] CPU_INFO = 32'h4E45_5354;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        exe_mode;
    logic [7:0]  irq;
    logic        int_detect;
    logic [3:0]  int_id;
    logic [29:0] id_pc, mem_pc, new_pc;
    logic        mem_en, mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic        if_busy, mem_busy, ld_hazard;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic        stack_ovf;

    int n_chk = 0;
    int n_err = 0;

    cpu_ctrl_nest #(.IRQ_CH(8), .STACK_DEPTH(DEPTH), .ROM_SIZE(8192), .SPM_SIZE(16384)) dut (
        .clk(clk), .reset(reset), .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
        .exe_mode(exe_mode), .irq(irq), .int_detect(int_detect), .int_id(int_id),
        .id_pc(id_pc), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out), .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .new_pc(new_pc), .stack_ovf(stack_ovf)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          model_valid = 0;
    bit          m_mode, m_inten, m_brf, m_ovf;
    logic [7:0]  m_mask, m_pend, m_irqq;
    logic [29:0] m_vec, m_prepc;
    logic [2:0]  m_code;
    logic [3:0]  m_irqid;
    int          m_sp;
    bit          m_pm [DEPTH];
    bit          m_pi [DEPTH];
    bit          m_dly [DEPTH];
    logic [29:0] m_epc [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int top_i();
        return (m_sp == 0) ? 0 : m_sp - 1;
    endfunction

    function automatic logic [7:0] pend_now();
`ifdef CPU_CTRL_IRQ_EDGE_EN
        return m_pend;
`else
        return irq;
`endif
    endfunction

    function automatic logic [3:0] exp_int_id();
        logic [7:0] a;
        a = ~m_mask & pend_now();
        for (int i = 0; i < 8; i++) if (a[i]) return 4'(i);
        return 4'd0;
    endfunction

    function automatic logic [31:0] exp_creg(input logic [4:0] a);
        int t;
        t = top_i();
        case (a)
            5'd0:    return {30'd0, m_inten, m_mode};
            5'd1:    return {30'd0, m_pi[t], m_pm[t]};
            5'd2:    return {id_pc, 2'b00};
            5'd3:    return {m_epc[t], 2'b00};
            5'd4:    return {m_vec, 2'b00};
            5'd5:    return (32'(m_irqid) << 8) | (32'(m_dly[t]) << 3) | 32'(m_code);
            5'd6:    return 32'(m_mask);
            5'd7:    return 32'(pend_now());
            5'd8:    return (32'(m_ovf) << 8) | 32'(m_sp);
            5'd29:   return 32'd8192;
            5'd30:   return 32'd16384;
            5'd31:   return CPU_INFO;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [29:0] exp_new_pc();
        if (!mem_en) return 30'd0;
        if (mem_exp_code != 0) return m_vec;
        if (mem_ctrl_op == 2) return m_epc[top_i()];
        if (mem_ctrl_op == 1) return mem_pc + 30'd1;
        return 30'd0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_inten = 0; m_brf = 0; m_ovf = 0; m_mask = 8'hFF; m_pend = 0; m_irqq = 0;
        m_vec = 0; m_prepc = 0; m_code = 0; m_irqid = 0; m_sp = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_pm[i] = 0; m_pi[i] = 0; m_dly[i] = 0; m_epc[i] = 0;
        end
    endtask

    task automatic model_step();
        bit stl, ex, rt, wr;
        int t, p;
        logic [3:0] id;
        logic [7:0] clr;
        stl = if_busy | mem_busy;
        ex  = (mem_exp_code != 0);
        rt  = (mem_ctrl_op == 2);
        wr  = (mem_ctrl_op == 1);
        t   = top_i();
        id  = exp_int_id();
        clr = 8'h00;
        if (mem_en && !stl) begin
            if (ex) begin
                p = (m_sp < DEPTH) ? m_sp : DEPTH - 1;
                if (m_sp == DEPTH) m_ovf = 1; else m_sp++;
                m_pm[p] = m_mode; m_pi[p] = m_inten; m_dly[p] = m_brf;
                m_epc[p] = m_brf ? m_prepc : mem_pc;
                m_mode = 0; m_inten = 0; m_code = mem_exp_code;
                if (mem_exp_code == 1) m_irqid = id;
            end else if (rt) begin
                m_mode = m_pm[t]; m_inten = m_pi[t];
                if (m_sp > 0) m_sp--;
            end else if (wr) begin
                case (mem_dst_addr)
                    5'd0: begin m_inten = mem_out[1]; m_mode = mem_out[0]; end
                    5'd1: begin m_pi[t] = mem_out[1]; m_pm[t] = mem_out[0]; end
                    5'd3: m_epc[t] = mem_out[31:2];
                    5'd4: m_vec = mem_out[31:2];
                    5'd5: begin m_dly[t] = mem_out[3]; m_code = mem_out[2:0]; end
                    5'd6: m_mask = mem_out[7:0];
                    5'd7: clr = mem_out[7:0];
                    5'd8: if (mem_out[8]) m_ovf = 0;
                    default: ;
                endcase
            end
            m_prepc = mem_pc; m_brf = mem_br_flag;
        end
`ifdef CPU_CTRL_IRQ_EDGE_EN
        m_pend = (m_pend & ~clr) | (irq & ~m_irqq);
        m_irqq = irq;
`endif
    endtask

    task automatic compare_all();
        bit stl, fl;
        stl = if_busy | mem_busy;
        fl  = mem_en & ((mem_exp_code != 0) | (mem_ctrl_op == 1) | (mem_ctrl_op == 2));
        check("creg_rd_data", creg_rd_data, exp_creg(creg_rd_addr));
        check("exe_mode", 32'(exe_mode), 32'(m_mode));
        check("int_detect", 32'(int_detect), 32'(m_inten & (|(~m_mask & pend_now()))));
        check("int_id", 32'(int_id), 32'(exp_int_id()));
        check("stalls", {28'd0, if_stall, id_stall, ex_stall, mem_stall},
              {28'd0, stl | ld_hazard, stl, stl, stl});
        check("flushes", {28'd0, if_flush, id_flush, ex_flush, mem_flush},
              {28'd0, fl, fl | ld_hazard, fl, fl});
        check("new_pc", 32'(new_pc), 32'(exp_new_pc()));
        check("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    endtask

    // Compare, then advance the model to the state the next rising edge will produce.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) compare_all();
            if (reset) begin
                model_reset();
                model_valid = 1;
            end else if (model_valid) begin
                model_step();
            end
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic set_idle();
        mem_en = 0; mem_br_flag = 0; mem_ctrl_op = 0; mem_dst_addr = 0; mem_exp_code = 0;
        mem_out = 0; if_busy = 0; mem_busy = 0; ld_hazard = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        creg_rd_addr = a;
        #1;
        check(name, creg_rd_data, exp);
    endtask

    task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
        mem_en = 1; mem_ctrl_op = 1; mem_dst_addr = a; mem_out = d;
        tick();
    endtask

    task automatic exc(input logic [29:0] pc, input logic [2:0] code, input string name);
        mem_en = 1; mem_pc = pc; mem_exp_code = code;
        #1;
        check(name, 32'(new_pc), 32'h100);
        tick();
    endtask

    task automatic exrt(input logic [29:0] exp_pc, input string name);
        mem_en = 1; mem_ctrl_op = 2;
        #1;
        check(name, 32'(new_pc), 32'(exp_pc));
        tick();
    endtask

    initial begin
        reset = 1; creg_rd_addr = 0; irq = 0; id_pc = 30'h0ABC; mem_pc = 0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rd(5'd6, 32'hFF, "reset_mask");
        rd(5'd8, 32'h0, "reset_sp");
        check("reset_exe_mode", 32'(exe_mode), 32'd0);
        reset = 0;
        tick();
        rd(5'd2, 32'h2AF0, "id_pc_read");

        // Nest three
        wrcr(5'd4, 32'h400);
        exc(30'h10, 3'd2, "nest_vec0");
        exc(30'h20, 3'd2, "nest_vec1");
        exc(30'h30, 3'd2, "nest_vec2");
        rd(5'd8, 32'h3, "nest_sp3");
        exrt(30'h30, "nest_ret0");
        exrt(30'h20, "nest_ret1");
        exrt(30'h10, "nest_ret2");
        rd(5'd8, 32'h0, "nest_sp0");

        // Overflow
        for (int i = 0; i < 5; i++) exc(30'h50 + 30'(i), 3'd3, "ovf_vec");
        rd(5'd8, 32'h104, "ovf_creg8");
        check("ovf_flag", 32'(stack_ovf), 32'd1);
        rd(5'd3, 32'h150, "ovf_top_epc");
        wrcr(5'd8, 32'h100);
        rd(5'd8, 32'h004, "ovf_cleared");
        exrt(30'h54, "ovf_ret0");
        exrt(30'h52, "ovf_ret1");
        exrt(30'h51, "ovf_ret2");
        exrt(30'h50, "ovf_ret3");
        rd(5'd8, 32'h0, "ovf_sp0");

        // Priority
        wrcr(5'd6, 32'hF0);
        wrcr(5'd0, 32'h2);
        irq = 8'h0C;
        tick();
        #1;
        check("prio_detect", 32'(int_detect), 32'd1);
        check("prio_id", 32'(int_id), 32'd2);
        wrcr(5'd6, 32'hFC);
        check("prio_masked", 32'(int_detect), 32'd0);
        irq = 8'h00;
`ifdef CPU_CTRL_IRQ_EDGE_EN
        wrcr(5'd7, 32'h0C);
`endif
        rd(5'd7, 32'h0, "prio_pend_clr");

        // Edge / level pending
`ifdef CPU_CTRL_IRQ_EDGE_EN
        irq = 8'h20;
        tick();
        irq = 8'h00;
        rd(5'd7, 32'h20, "edge_latched");
        wrcr(5'd7, 32'h20);
        rd(5'd7, 32'h00, "edge_cleared");
        irq = 8'h20;
        wrcr(5'd7, 32'h20);
        irq = 8'h00;
        rd(5'd7, 32'h20, "edge_set_wins");
        wrcr(5'd7, 32'h20);
        rd(5'd7, 32'h00, "edge_cleared2");
`else
        irq = 8'h20;
        wrcr(5'd7, 32'h20);
        rd(5'd7, 32'h20, "level_follows");
        irq = 8'h00;
        rd(5'd7, 32'h00, "level_drop");
`endif

        // Stall
        mem_en = 1; mem_pc = 30'h60; mem_exp_code = 3'd3; mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            creg_rd_addr = 5'd8;
            #1;
            check("stall_sp_held", creg_rd_data, 32'h0);
            check("stall_mem_stall", 32'(mem_stall), 32'd1);
            check("stall_flush", 32'(mem_flush), 32'd1);
            @(posedge clk);
            #1;
        end
        mem_busy = 0;
        tick();
        rd(5'd8, 32'h1, "stall_sp_once");
        tick();
        rd(5'd8, 32'h1, "stall_sp_stays");

        // Delay slot
        mem_en = 1; mem_pc = 30'h40; mem_br_flag = 1;
        tick();
        exc(30'h41, 3'd2, "dly_vec");
        rd(5'd3, 32'h100, "dly_epc");
        rd(5'd5, 32'h0A, "dly_creg5");

        // Reset mid-exception
        reset = 1;
        tick();
        tick();
        reset = 0;
        rd(5'd8, 32'h0, "rst_sp");
        rd(5'd3, 32'h0, "rst_epc");
        tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            reset        = ($urandom_range(0, 199) == 0);
            mem_en       = ($urandom_range(0, 3) != 0);
            mem_pc       = 30'($urandom);
            id_pc        = 30'($urandom);
            mem_br_flag  = ($urandom_range(0, 3) == 0);
            mem_exp_code = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            mem_ctrl_op  = 2'($urandom_range(0, 3));
            mem_dst_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
            mem_out      = $urandom;
            if_busy      = ($urandom_range(0, 7) == 0);
            mem_busy     = ($urandom_range(0, 7) == 0);
            ld_hazard    = ($urandom_range(0, 5) == 0);
            creg_rd_addr = 5'($urandom);
            if ($urandom_range(0, 2) == 0) irq = irq ^ (8'h01 << $urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        reset = 0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_nest.md
# cpu_ctrl_nest

Parametrised CPU control unit for the five-stage pipeline, sitting beside the MEM stage. It generates stall and flush signals and holds the control-register file (CREG). It adds three things to the base control unit:
- a configurable number of IRQ channels with a priority encoder;
- a hardware exception stack that allows nested exceptions and EXRT returns up to `STACK_DEPTH` levels;
- optional edge-latched interrupt pending bits.

## Interface
Parameters:
- `IRQ_CH`, 8, number of interrupt channels (1..16).
- `STACK_DEPTH`, 4, number of nested exception levels (power of two, 2..16).
- `ROM_SIZE`, 8192, value returned by CREG 29.
- `SPM_SIZE`, 16384, value returned by CREG 30.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `creg_rd_addr`  in  5  CREG read address (from ID).
- `creg_rd_data`  out  32  CREG read data, combinational.
- `exe_mode`  out  1  current mode, 0 = kernel.
- `irq`  in  `IRQ_CH`  interrupt request lines.
- `int_detect`  out  1  unmasked pending interrupt present and enabled.
- `int_id`  out  4  lowest-numbered unmasked pending channel, 0 if none.
- `id_pc`  in  30  ID-stage word PC.
- `mem_pc`  in  30  MEM-stage word PC.
- `mem_en`  in  1  MEM-stage valid.
- `mem_br_flag`  in  1  MEM instruction is a branch.
- `mem_ctrl_op`  in  2  0 none, 1 WRCR, 2 EXRT.
- `mem_dst_addr`  in  5  CREG write address.
- `mem_exp_code`  in  3  exception code, 0 = none, 1 = external interrupt.
- `mem_out`  in  32  CREG write data.
- `if_busy`, `mem_busy`, `ld_hazard`  in  1 each  pipeline status.
- `if_stall`, `id_stall`, `ex_stall`, `mem_stall`  out  1 each.
- `if_flush`, `id_flush`, `ex_flush`, `mem_flush`  out  1 each.
- `new_pc`  out  30  redirect target.
- `stack_ovf`  out  1  sticky flag: a push occurred while the stack was full.

## Operation
Stall and flush:
- `stall = if_busy | mem_busy`.
- `if_stall = stall | ld_hazard`; the other three stalls equal `stall`.
- `flush` is asserted for exception, EXRT or WRCR while `mem_en` = 1.
- `id_flush = flush | ld_hazard`; the other three flushes equal `flush`.

Redirect target (`new_pc`):
- Exception: `exp_vector`.
- EXRT: `epc` of the top stack entry.
- WRCR: `mem_pc + 1`.
- Otherwise: 0.

Exception stack:
- Each entry holds {`pre_exe_mode`, `pre_int_en`, `epc[29:0]`, `dly_flag`}.
- `sp` runs 0..`STACK_DEPTH`. The top entry is `stack[sp-1]`, or `stack[0]` when `sp` = 0.

State updates happen only when `mem_en` = 1 and `stall` = 0, in priority order:
- **Exception:**
  - Push {`exe_mode`, `int_en`, `br_flag ? pre_pc : mem_pc`, `br_flag`}.
  - Set `exe_mode` = 0 and `int_en` = 0.
  - `exp_code <= mem_exp_code`.
  - If the code is 1, `irq_id <= int_id`.
  - If `sp` = `STACK_DEPTH`, overwrite the top entry, leave `sp` unchanged and set `stack_ovf`.
- **EXRT:**
  - Restore `exe_mode` and `int_en` from the top entry.
  - Decrement `sp` if it is greater than 0; at `sp` = 0, restore from `stack[0]` and `sp` stays 0.
- **WRCR:** write the CREG at `mem_dst_addr`. Writes to read-only or reserved addresses are ignored.

Every accepted MEM instruction also updates `pre_pc <= mem_pc` and `br_flag <= mem_br_flag`.

CREG map (read; write where noted):
- 0 {`int_en`, `exe_mode`}: RW.
- 1 top-entry {`pre_int_en`, `pre_exe_mode`}: RW.
- 2 {`id_pc`, 2'b0}: RO.
- 3 {top `epc`, 2'b0}: RW.
- 4 {`exp_vector`, 2'b0}: RW.
- 5 {`irq_id`[11:8], `dly_flag`[3], `exp_code`[2:0]}: `dly_flag` and `exp_code` RW.
- 6 `mask`: RW, 1 = masked.
- 7 `pending`: see Configuration.
- 8 {`stack_ovf`[8], `sp`}: writing bit 8 = 1 clears `stack_ovf`.
- 29 `ROM_SIZE`, 30 `SPM_SIZE`, 31 CPU info.
- All other addresses read 0.

Interrupt detection:
- `int_detect = int_en & |(~mask & pending)`.
- `int_id` is the priority-encoded result of `~mask & pending`, lowest index wins.

## Timing
- All outputs except registered state are combinational, with zero latency.
- A CREG write is visible on `creg_rd_data` the cycle after the WRCR is accepted.
- Reset values:
  - `exe_mode` = 0, `int_en` = 0, `mask` = all 1s, `exp_vector` = 0.
  - `sp` = 0, all stack entries 0, `stack_ovf` = 0.
  - `exp_code` = 0, `irq_id` = 0, `pending` = 0, `pre_pc` = 0, `br_flag` = 0.
- With reset held, all outputs show reset values after the first edge. A reset mid-exception discards the stack.
- When `stall` = 1, no state updates occur (pending capture excepted), but `flush` and `new_pc` still follow the MEM inputs.

## Configuration
`CPU_CTRL_IRQ_EDGE_EN`:
- **Defined:**
  - `irq` is registered into `irq_q`.
  - A rising edge (`irq & ~irq_q`) sets the `pending` bit every cycle, regardless of stall.
  - Writing CREG 7 is write-1-to-clear. A set and a clear in the same cycle: set wins.
- **Undefined:**
  - `pending = irq` (level-sensitive).
  - Writes to CREG 7 are ignored.
  - `irq_q` is not implemented.

## Test plan
- **Nest three:** exceptions with `mem_pc` 0x10, 0x20, 0x30 and `exp_vector` = 0x100. Expect `sp` = 3 and `new_pc` = 0x100 each time. Three EXRTs then return `new_pc` 0x30, 0x20, 0x10, with `sp` reaching 0.
- **Overflow:** with `STACK_DEPTH` = 4, five exceptions. Expect `sp` = 4 and `stack_ovf` = 1. CREG 8 reads 0x104. Writing 0x100 clears it.
- **Priority:** `mask` = 0xF0, `irq` = 0x0C, `int_en` = 1. Expect `int_detect` = 1 and `int_id` = 2. Set `mask` = 0xFC: `int_detect` = 0.
- **Edge mode:** pulse `irq[5]` for 1 cycle. CREG 7 reads 0x20. Write 0x20 to CREG 7: reads 0x00. A simultaneous edge and clear leaves 0x20.
- **Stall:** exception held with `mem_busy` = 1 for 3 cycles. `sp` is unchanged until `mem_busy` falls, then increments exactly once.
- **Delay slot:** branch at 0x40, then exception at 0x41. Expect `epc` = 0x40 and CREG 5 bit 3 = 1.
